// File: rtl/serial_parity_checker.sv
// Serial frame receiver: FRAME_LEN data bits (LSB first) followed by one parity bit.
// Keeps a running parity through a mux-built XOR and flags frames whose parity bit disagrees.
module serial_parity_checker #(
  parameter int FRAME_LEN  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [FRAME_LEN-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    RX_DATA = 2'd0,
    RX_PAR  = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_acc;
  logic [FRAME_LEN-1:0] r_shift;
  logic [FRAME_LEN-1:0] r_data;
  logic                 r_err;
  logic                 r_done;
  logic                 r_ready;
  logic                 r_busy;

  logic w_accept;
  logic w_acc_next;

  assign w_accept   = bit_valid & r_ready;
  // Running parity as a 2:1 mux selecting the inverted or true bit.
  assign w_acc_next = r_acc ? ~bit_in : bit_in;

  // NOTE: all state here updates with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, exactly like the flops it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_DATA;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        RX_DATA: begin
          if (clr) begin
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_shift <= '0;
            r_busy  <= 1'b0;
          end else if (w_accept) begin
            r_shift <= {bit_in, r_shift[FRAME_LEN-1:1]};
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + 1'b1;
            r_busy  <= 1'b1;
            if (r_cnt == CNT_W'(FRAME_LEN - 1)) r_state <= RX_PAR;
          end
        end
        RX_PAR: begin
          if (clr) begin
            r_state <= RX_DATA;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_shift <= '0;
            r_busy  <= 1'b0;
          end else if (w_accept) begin
            r_data  <= r_shift;
            r_err   <= w_acc_next ^ ODD_PARITY;
            r_state <= DONE;
            r_done  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        DONE: begin
          // DONE always completes; a clr seen here only additionally wipes the shifter.
          r_state <= RX_DATA;
          r_cnt   <= '0;
          r_acc   <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (clr) r_shift <= '0;
        end
        default: begin
          r_state <= RX_DATA;
          r_cnt   <= '0;
          r_acc   <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready  = r_ready;
  assign data_out   = r_data;
  assign parity_err = r_err;
  assign frame_done = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: one even-parity and one odd-parity
// instance share the same input stream; expected values are hand-computed.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;

  logic       bit_ready, parity_err, frame_done, busy;
  logic [7:0] data_out;
  logic       o_bit_ready, o_parity_err, o_frame_done, o_busy;
  logic [7:0] o_data_out;

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;
  int n_ready_low = 0;

  serial_parity_checker #(.FRAME_LEN(8), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .data_out(data_out), .parity_err(parity_err),
    .frame_done(frame_done), .busy(busy)
  );

  serial_parity_checker #(.FRAME_LEN(8), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(o_bit_ready), .data_out(o_data_out), .parity_err(o_parity_err),
    .frame_done(o_frame_done), .busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (!bit_ready) n_ready_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one bit and hold it until accepted; optionally idle for gap cycles afterwards.
  task automatic send_bit(input logic b, input int gap);
    int waited = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    while (!bit_ready && waited < 10) begin
      tick();
      waited++;
    end
    if (waited >= 10) check("ready_timeout", {31'd0, bit_ready}, 32'd1);
    tick();
    if (gap > 0) begin
      bit_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  // After return the DUT is in its DONE cycle with bit_valid low.
  task automatic send_frame(input logic [7:0] d, input logic par, input int gap, input bit chk_busy);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], gap);
      if (chk_busy) check("busy_mid_frame", {31'd0, busy}, 32'd1);
    end
    send_bit(par, 0);
    bit_valid = 1'b0;
  endtask

  initial begin
    int done0;

    // Reset state
    repeat (2) tick();
    check("rst_data_out", {24'd0, data_out}, 32'h0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_bit_ready", {31'd0, bit_ready}, 32'd1);

    // 1: even parity, good frame
    send_frame(8'hA5, 1'b0, 0, 1'b0);
    check("t1_frame_done", {31'd0, frame_done}, 32'd1);
    check("t1_ready_low", {31'd0, bit_ready}, 32'd0);
    check("t1_data", {24'd0, data_out}, 32'hA5);
    check("t1_err", {31'd0, parity_err}, 32'd0);
    check("t1_odd_err", {31'd0, o_parity_err}, 32'd1);
    tick();
    check("t1_done_pulse_end", {31'd0, frame_done}, 32'd0);
    check("t1_ready_back", {31'd0, bit_ready}, 32'd1);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // 2: even parity, bad frame
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    check("t2_data", {24'd0, data_out}, 32'hA5);
    check("t2_err", {31'd0, parity_err}, 32'd1);
    tick();

    // 3: gaps of three idle cycles between bits
    check("t3_busy_before", {31'd0, busy}, 32'd0);
    done0 = n_done;
    send_frame(8'h3C, 1'b0, 3, 1'b1);
    check("t3_busy_in_done", {31'd0, busy}, 32'd1);
    check("t3_data", {24'd0, data_out}, 32'h3C);
    check("t3_err", {31'd0, parity_err}, 32'd0);
    repeat (3) tick();
    check("t3_done_count", n_done - done0, 32'd1);

    // 4: back-to-back frames with bit_valid held high
    n_ready_low = 0;
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    check("t4a_data", {24'd0, data_out}, 32'hFF);
    check("t4a_err", {31'd0, parity_err}, 32'd0);
    send_frame(8'h01, 1'b0, 0, 1'b0);
    check("t4b_data", {24'd0, data_out}, 32'h01);
    check("t4b_err", {31'd0, parity_err}, 32'd1);
    tick();
    check("t4_ready_low_cycles", n_ready_low, 32'd2);

    // 5: abort after 5 bits, then a complete frame
    done0 = n_done;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    bit_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_busy_after_clr", {31'd0, busy}, 32'd0);
    check("t5_data_held", {24'd0, data_out}, 32'h01);
    check("t5_err_held", {31'd0, parity_err}, 32'd1);
    send_frame(8'h0F, 1'b0, 0, 1'b0);
    check("t5_data", {24'd0, data_out}, 32'h0F);
    check("t5_err", {31'd0, parity_err}, 32'd0);
    repeat (2) tick();
    check("t5_done_count", n_done - done0, 32'd1);

    // 6: odd-parity instance, then reset mid-frame
    send_frame(8'h01, 1'b0, 0, 1'b0);
    check("t6a_odd_data", {24'd0, o_data_out}, 32'h01);
    check("t6a_odd_err", {31'd0, o_parity_err}, 32'd0);
    tick();
    send_frame(8'h03, 1'b0, 0, 1'b0);
    check("t6b_odd_data", {24'd0, o_data_out}, 32'h03);
    check("t6b_odd_err", {31'd0, o_parity_err}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    bit_valid = 1'b0;
    check("t6_busy_mid", {31'd0, o_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_data", {24'd0, o_data_out}, 32'h0);
    check("t6_rst_err", {31'd0, o_parity_err}, 32'd0);
    check("t6_rst_done", {31'd0, o_frame_done}, 32'd0);
    check("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    check("t6_rst_even_data", {24'd0, data_out}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_ready_after_rst", {31'd0, o_bit_ready}, 32'd1);
    check("t6_done_after_rst", {31'd0, o_frame_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
